// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single mem_system port between an instruction-fetch requester
//   (read-only) and a data requester (read/write). The winner's address,
//   write data and direction are latched in IDLE and held stable until the
//   transaction ends. Rd/Wr pulse for exactly one cycle once the port is not
//   stalled. A watchdog bounds every transaction, and a registered
//   done/rdata is returned to the owning requester.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on contention, grant the requester that did not win last time
//   undefined : fixed priority, data beats fetch
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   i_req/i_addr               fetch request (read-only)
//   i_done/i_rdata             fetch completion pulse and read data
//   d_req/d_wr/d_addr/d_wdata  data request
//   d_done/d_rdata             data completion pulse and read data
//   busy                       transaction in progress
//   err                        pulses with done on timeout or mem_err
//   mem_addr/mem_wdata         latched address / write data to the port
//   mem_rd/mem_wr              one-cycle command strobes
//   mem_rdata/mem_done         port read data and completion
//   mem_stall/mem_err          port back-pressure and error
//
// States
//   state   | meaning
//   S_IDLE  | waiting for a request, arbitration happens here
//   S_ISSUE | request latched, strobe Rd/Wr once mem_stall is low
//   S_WAIT  | command issued, waiting for mem_done or watchdog expiry
//   S_RESP  | one-cycle done (and err) pulse to the owner

module mem_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic              mem_stall,
    input  logic              mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;
    localparam int   TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              winner;

    // Only consulted when at least one request is present; the no-request
    // case simply repeats the previous grant.
`ifdef ARB_ROUND_ROBIN_EN
    assign winner = (d_req && i_req) ? ~last_gnt_q : d_req;
`else
    assign winner = d_req | (~i_req & last_gnt_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_INST;
            last_gnt_q <= OWN_INST;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        wr_d       = wr_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        timer_d    = timer_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_req || i_req) begin
                    owner_d    = winner;
                    last_gnt_d = winner;
                    err_d      = 1'b0;
                    if (winner == OWN_DATA) begin
                        addr_d  = d_addr;
                        wr_d    = d_wr;
                        wdata_d = d_wr ? d_wdata : '0;
                    end else begin
                        addr_d  = i_addr;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_stall) begin
                    mem_rd  = ~wr_q;
                    mem_wr  = wr_q;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (mem_done) begin
                    if (owner_q == OWN_DATA) d_rdata_d = mem_rdata;
                    else                     i_rdata_d = mem_rdata;
                    err_d   = mem_err;
                    state_d = S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    // Watchdog abort: the owner sees zero data and an error.
                    if (owner_q == OWN_DATA) d_rdata_d = '0;
                    else                     i_rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                i_done  = (owner_q == OWN_INST);
                d_done  = (owner_q == OWN_DATA);
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_done;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        busy;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata = '0;
    logic        mem_done = 1'b0;
    logic        mem_stall = 1'b0;
    logic        mem_err = 1'b0;

    int tests = 0;
    int fails = 0;

    logic        resp_en = 1'b1;
    logic [15:0] resp_data = '0;
    logic        resp_err = 1'b0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .busy(busy), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Cache-hit memory model: Done one cycle after the Rd/Wr strobe.
    initial begin
        forever begin
            @(negedge clk);
            if ((mem_rd || mem_wr) && resp_en) begin
                @(posedge clk); #1;
                mem_done  = 1'b1;
                mem_rdata = resp_data;
                mem_err   = resp_err;
                @(posedge clk); #1;
                mem_done = 1'b0;
                mem_err  = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; mem_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_done(output bit ok);
        int n;
        n = 0;
        while (n < 100 && !(i_done || d_done)) begin
            tick();
            n++;
        end
        ok = i_done || d_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if (busy !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl busy=%b rd=%b wr=%b expected 0 0 0", busy, mem_rd, mem_wr);
        end
        tests++;
        if (i_done !== 1'b0 || d_done !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL reset_done i_done=%b d_done=%b err=%b expected 0 0 0", i_done, d_done, err);
        end
        tests++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || i_rdata !== 16'h0 || d_rdata !== 16'h0) begin
            fails++; $display("FAIL reset_data addr=%h wdata=%h i_rdata=%h d_rdata=%h expected 0", mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        resp_en = 1'b1; resp_data = 16'hBEEF; resp_err = 1'b0;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100; d_wdata = 16'hFFFF;
        tick();
        tests++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0100) begin
            fails++; $display("FAIL rd_issue rd=%b wr=%b addr=%h expected 1 0 0100", mem_rd, mem_wr, mem_addr);
        end
        tests++;
        if (mem_wdata !== 16'h0) begin
            fails++; $display("FAIL rd_wdata_zero got %h expected 0000", mem_wdata);
        end
        tick();
        tests++;
        if (mem_rd !== 1'b0 || busy !== 1'b1 || d_done !== 1'b0) begin
            fails++; $display("FAIL rd_wait rd=%b busy=%b d_done=%b expected 0 1 0", mem_rd, busy, d_done);
        end
        tick();
        tests++;
        if (d_done !== 1'b1 || d_rdata !== 16'hBEEF || i_done !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL rd_done d_done=%b d_rdata=%h i_done=%b err=%b expected 1 BEEF 0 0", d_done, d_rdata, i_done, err);
        end
        d_req = 1'b0;
        tick();
        tests++;
        if (d_done !== 1'b0 || busy !== 1'b0 || d_rdata !== 16'hBEEF) begin
            fails++; $display("FAIL rd_after d_done=%b busy=%b d_rdata=%h expected 0 0 BEEF", d_done, busy, d_rdata);
        end
    endtask

    task automatic test_priority();
        do_reset();
        resp_en = 1'b1; resp_data = 16'hCAFE;
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        tick();
        tests++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
            fails++; $display("FAIL prio_d_first wr=%b rd=%b addr=%h wdata=%h expected 1 0 0200 1234", mem_wr, mem_rd, mem_addr, mem_wdata);
        end
        tick(); tick();
        tests++;
        if (d_done !== 1'b1 || i_done !== 1'b0) begin
            fails++; $display("FAIL prio_d_done d_done=%b i_done=%b expected 1 0", d_done, i_done);
        end
        d_req = 1'b0; d_wr = 1'b0;
        tick(); tick();
        tests++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0010 || mem_wdata !== 16'h0) begin
            fails++; $display("FAIL prio_i_second rd=%b wr=%b addr=%h wdata=%h expected 1 0 0010 0000", mem_rd, mem_wr, mem_addr, mem_wdata);
        end
        tick(); tick();
        tests++;
        if (i_done !== 1'b1 || i_rdata !== 16'hCAFE || d_done !== 1'b0) begin
            fails++; $display("FAIL prio_i_done i_done=%b i_rdata=%h d_done=%b expected 1 CAFE 0", i_done, i_rdata, d_done);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_addr [4];
        bit ok;
        int n;
`ifdef ARB_ROUND_ROBIN_EN
        exp_addr = '{16'h0300, 16'h0020, 16'h0300, 16'h0020};
`else
        exp_addr = '{16'h0300, 16'h0300, 16'h0300, 16'h0300};
`endif
        do_reset();
        resp_en = 1'b1; resp_data = 16'h0F0F;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
        i_req = 1'b1; i_addr = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (n < 20 && !(mem_rd || mem_wr)) begin
                tick();
                n++;
            end
            tests++;
            if (mem_rd !== 1'b1 || mem_addr !== exp_addr[k]) begin
                fails++; $display("FAIL b2b_grant%0d rd=%b addr=%h expected 1 %h", k, mem_rd, mem_addr, exp_addr[k]);
            end
            wait_done(ok);
            tests++;
            if (!ok || (exp_addr[k] == 16'h0300 && d_done !== 1'b1) || (exp_addr[k] == 16'h0020 && i_done !== 1'b1)) begin
                fails++; $display("FAIL b2b_done%0d i_done=%b d_done=%b expected owner of %h", k, i_done, d_done, exp_addr[k]);
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        resp_en = 1'b1; resp_data = 16'h2222;
        mem_stall = 1'b1;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (mem_rd !== 1'b0 || mem_addr !== 16'h0400 || busy !== 1'b1) begin
                fails++; $display("FAIL stall_hold%0d rd=%b addr=%h busy=%b expected 0 0400 1", k, mem_rd, mem_addr, busy);
            end
        end
        mem_stall = 1'b0;
        #1;
        tests++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0400) begin
            fails++; $display("FAIL stall_release rd=%b addr=%h expected 1 0400", mem_rd, mem_addr);
        end
        tick();
        tests++;
        if (mem_rd !== 1'b0 || mem_addr !== 16'h0400) begin
            fails++; $display("FAIL stall_single_pulse rd=%b addr=%h expected 0 0400", mem_rd, mem_addr);
        end
        wait_done(ok);
        tests++;
        if (!ok || d_done !== 1'b1 || d_rdata !== 16'h2222) begin
            fails++; $display("FAIL stall_done d_done=%b d_rdata=%h expected 1 2222", d_done, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_mem_err();
        bit ok;
        resp_en = 1'b1; resp_data = 16'h0000; resp_err = 1'b1;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0600; d_wdata = 16'hA5A5;
        tick();
        tests++;
        if (mem_wr !== 1'b1 || mem_wdata !== 16'hA5A5) begin
            fails++; $display("FAIL merr_issue wr=%b wdata=%h expected 1 A5A5", mem_wr, mem_wdata);
        end
        wait_done(ok);
        tests++;
        if (!ok || d_done !== 1'b1 || err !== 1'b1) begin
            fails++; $display("FAIL merr_done d_done=%b err=%b expected 1 1", d_done, err);
        end
        d_req = 1'b0; d_wr = 1'b0; resp_err = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit early;
        bit ok;
        do_reset();
        resp_en = 1'b1; resp_data = 16'h5A5A;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
        tick(); tick(); tick();
        tests++;
        if (d_done !== 1'b1 || d_rdata !== 16'h5A5A) begin
            fails++; $display("FAIL to_pre d_done=%b d_rdata=%h expected 1 5A5A", d_done, d_rdata);
        end
        d_req = 1'b0;
        tick();
        resp_en = 1'b0;
        d_req = 1'b1; d_addr = 16'h0510;
        tick();
        early = 1'b0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (d_done !== 1'b0 || busy !== 1'b1) early = 1'b1;
        end
        tests++;
        if (early !== 1'b0) begin
            fails++; $display("FAIL to_early got early_done=%b expected 0", early);
        end
        tick();
        tests++;
        if (d_done !== 1'b1 || err !== 1'b1 || d_rdata !== 16'h0) begin
            fails++; $display("FAIL to_abort d_done=%b err=%b d_rdata=%h expected 1 1 0000", d_done, err, d_rdata);
        end
        d_req = 1'b0;
        tick();
        tests++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL to_err_clear err=%b busy=%b expected 0 0", err, busy);
        end
        resp_en = 1'b1; resp_data = 16'h1357;
        i_req = 1'b1; i_addr = 16'h0060;
        wait_done(ok);
        tests++;
        if (!ok || i_done !== 1'b1 || i_rdata !== 16'h1357 || err !== 1'b0) begin
            fails++; $display("FAIL to_next i_done=%b i_rdata=%h err=%b expected 1 1357 0", i_done, i_rdata, err);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bit seen;
        bit ok;
        do_reset();
        resp_en = 1'b0;
        i_req = 1'b1; i_addr = 16'h0070;
        tick();
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (mem_rd !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL arst_issue rd=%b busy=%b expected 0 0", mem_rd, busy);
        end
        rst_n = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            fails++; $display("FAIL arst_wait busy=%b rd=%b wr=%b expected 0 0 0", busy, mem_rd, mem_wr);
        end
        i_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (i_done !== 1'b0 || d_done !== 1'b0 || err !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL arst_no_done got done_seen=%b expected 0", seen);
        end
        rst_n = 1'b1;
        tick();
        resp_en = 1'b1; resp_data = 16'h4242;
        i_req = 1'b1; i_addr = 16'h0040;
        tick();
        tests++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin
            fails++; $display("FAIL arst_reissue rd=%b addr=%h expected 1 0040", mem_rd, mem_addr);
        end
        wait_done(ok);
        tests++;
        if (!ok || i_done !== 1'b1 || i_rdata !== 16'h4242 || err !== 1'b0) begin
            fails++; $display("FAIL arst_recover i_done=%b i_rdata=%h err=%b expected 1 4242 0", i_done, i_rdata, err);
        end
        i_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_back_to_back();
        test_stall();
        test_mem_err();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
